// File: rtl/pattern_classifier_if.sv
// Avalon-MM register bundle and Avalon-ST streaming bundle used by pattern_classifier.

interface avalon_mm_if #(
    parameter int AW = 8,
    parameter int DW = 32
);
    logic [AW-1:0] address;
    logic          read;
    logic          write;
    logic [DW-1:0] writedata;
    logic [DW-1:0] readdata;

    modport master (output address, read, write, writedata, input readdata);
    modport slave  (input address, read, write, writedata, output readdata);
endinterface

interface avalon_st_if #(
    parameter int DW = 64,
    parameter int CW = 2,
    parameter int EW = 3
);
    logic [DW-1:0] data;
    logic          valid;
    logic          ready;
    logic          startofpacket;
    logic          endofpacket;
    logic [EW-1:0] empty;
    logic [CW-1:0] channel;

    modport src  (output data, valid, startofpacket, endofpacket, empty, channel, input ready);
    modport sink (input data, valid, startofpacket, endofpacket, empty, channel, output ready);
endinterface

// File: rtl/pattern_classifier.sv
// Inline Avalon-ST packet classifier: tags each EOP beat with the lowest-index matching
// byte pattern (any alignment, across beats) and counts packets per class over Avalon-MM.

module pattern_classifier #(
    parameter int AMM_DWIDTH    = 32,
    parameter int AST_DWIDTH    = 64,
    parameter int CHANNEL_WIDTH = 2,
    parameter int N_PATTERNS    = 3,
    parameter int PAT_BYTES     = 12
) (
    input  logic       clk_i,
    input  logic       srst_i,
    avalon_mm_if.slave amm_slave_if,
    avalon_st_if.sink  ast_sink_if,
    avalon_st_if.src   ast_src_if
);
    localparam int BPB      = AST_DWIDTH / 8;
    localparam int EW       = (BPB > 1) ? $clog2(BPB) : 1;
    localparam int PW       = PAT_BYTES / 4;
    localparam int HB       = PAT_BYTES - 1;
    localparam int SL       = HB + BPB;
    localparam int HCW      = $clog2(PAT_BYTES);
    localparam int CNT_BASE = 1 + N_PATTERNS * PW;

    function automatic logic [7:0] pat_byte(input logic [31:0] word, input int idx);
        return word[31-8*idx -: 8];
    endfunction

    logic [N_PATTERNS:0]      ctrl_q, ctrl_d;
    logic [AMM_DWIDTH-1:0]    pat_q [N_PATTERNS][PW];
    logic [AMM_DWIDTH-1:0]    pat_d [N_PATTERNS][PW];
    logic [AMM_DWIDTH-1:0]    cnt_q [N_PATTERNS+1];
    logic [AMM_DWIDTH-1:0]    cnt_d [N_PATTERNS+1];
    logic [AMM_DWIDTH-1:0]    rdata_q, rdata_d;
    logic [7:0]               hist_q [HB];
    logic [7:0]               hist_d [HB];
    logic [HCW-1:0]           hist_cnt_q, hist_cnt_d;
    logic [N_PATTERNS-1:0]    hit_q, hit_d;
    logic                     in_pkt_q, in_pkt_d, pkt_en_q, pkt_en_d;
    logic                     valid_q, valid_d, sop_q, sop_d, eop_q, eop_d;
    logic [AST_DWIDTH-1:0]    data_q, data_d;
    logic [EW-1:0]            empty_q, empty_d;
    logic [CHANNEL_WIDTH-1:0] chan_q, chan_d;

    logic                     sink_ready_s, accept_s, live_s, sop_s, eop_s, count_s, wr_s;
    logic                     unused_s;
    logic [7:0]               seq_s [SL];
    int                       n_s, base_cnt_s, hist_tot_s, addr_s;
    logic [N_PATTERNS-1:0]    beat_hit_s, hit_all_s;
    logic [CHANNEL_WIDTH-1:0] class_s;

    assign sink_ready_s = ~valid_q | ast_src_if.ready;
    assign sop_s        = ast_sink_if.startofpacket;
    assign eop_s        = ast_sink_if.endofpacket;
    assign accept_s     = ast_sink_if.valid & sink_ready_s;
    assign live_s       = sop_s | in_pkt_q;
    assign count_s      = accept_s & live_s & eop_s;
    assign wr_s         = amm_slave_if.write;
    assign addr_s       = int'(amm_slave_if.address);
    assign unused_s     = ^ast_sink_if.channel;

    // Match search over S = history ++ beat; a hit may end at any valid beat byte.
    always_comb begin
        logic eq_v;
        for (int i = 0; i < HB; i++) begin
            seq_s[i] = hist_q[i];
        end
        for (int i = 0; i < BPB; i++) begin
            seq_s[HB+i] = ast_sink_if.data[AST_DWIDTH-1-8*i -: 8];
        end
        n_s        = eop_s ? (BPB - int'(ast_sink_if.empty)) : BPB;
        base_cnt_s = sop_s ? 32'sd0 : int'(hist_cnt_q);
        hist_tot_s = base_cnt_s + n_s;
        for (int p = 0; p < N_PATTERNS; p++) begin
            beat_hit_s[p] = 1'b0;
            for (int j = 0; j < BPB; j++) begin
                eq_v = 1'b1;
                for (int b = 0; b < PAT_BYTES; b++) begin
                    eq_v = eq_v & (seq_s[j+b] == pat_byte(pat_q[p][b/4], b % 4));
                end
                beat_hit_s[p] = beat_hit_s[p] | (eq_v & (j < n_s) & (base_cnt_s + j + 1 >= PAT_BYTES));
            end
            beat_hit_s[p] = beat_hit_s[p] & ctrl_q[p+1] & (sop_s ? ctrl_q[0] : pkt_en_q);
        end
        hit_all_s = (sop_s ? {N_PATTERNS{1'b0}} : hit_q) | beat_hit_s;
        class_s   = {CHANNEL_WIDTH{1'b0}};
        for (int p = N_PATTERNS - 1; p >= 0; p--) begin
            class_s = hit_all_s[p] ? CHANNEL_WIDTH'(p + 1) : class_s;
        end
    end

    // Next state of the packet tracker, history window and output stage.
    always_comb begin
        for (int k = 0; k < HB; k++) begin
            hist_d[k] = (accept_s & live_s) ? seq_s[n_s+k] : hist_q[k];
        end
        hist_cnt_d = (accept_s & live_s) ? HCW'((hist_tot_s > HB) ? HB : hist_tot_s) : hist_cnt_q;
        hit_d      = (accept_s & live_s) ? hit_all_s : hit_q;
        pkt_en_d   = (accept_s & sop_s) ? ctrl_q[0] : pkt_en_q;
        in_pkt_d   = accept_s ? (~eop_s & live_s) : in_pkt_q;
        valid_d    = accept_s | (valid_q & ~ast_src_if.ready);
        data_d     = accept_s ? ast_sink_if.data : data_q;
        sop_d      = accept_s ? sop_s : sop_q;
        eop_d      = accept_s ? eop_s : eop_q;
        empty_d    = accept_s ? ast_sink_if.empty : empty_q;
        chan_d     = accept_s ? (count_s ? class_s : {CHANNEL_WIDTH{1'b0}}) : chan_q;
    end

    // Register file: host writes (a clear beats a same-cycle increment) and read mux.
    always_comb begin
        logic [AMM_DWIDTH-1:0] rd_v;
        ctrl_d = (wr_s & (addr_s == 0)) ? amm_slave_if.writedata[N_PATTERNS:0] : ctrl_q;
        rd_v   = (addr_s == 0) ? AMM_DWIDTH'(ctrl_q) : {AMM_DWIDTH{1'b0}};
        for (int p = 0; p < N_PATTERNS; p++) begin
            for (int w = 0; w < PW; w++) begin
                pat_d[p][w] = (wr_s & (addr_s == 1 + p * PW + w)) ? amm_slave_if.writedata : pat_q[p][w];
                rd_v        = (addr_s == 1 + p * PW + w) ? pat_q[p][w] : rd_v;
            end
        end
        for (int c = 0; c <= N_PATTERNS; c++) begin
            cnt_d[c] = (wr_s & (addr_s == CNT_BASE + c)) ? {AMM_DWIDTH{1'b0}} :
                       cnt_q[c] + {{(AMM_DWIDTH-1){1'b0}}, count_s & (class_s == CHANNEL_WIDTH'(c))};
            rd_v     = (addr_s == CNT_BASE + c) ? cnt_q[c] : rd_v;
        end
        rdata_d = amm_slave_if.read ? rd_v : {AMM_DWIDTH{1'b0}};
    end

    // State registers; reset also drops src.valid immediately.
    always_ff @(posedge clk_i or posedge srst_i) begin
        if (srst_i) begin
            ctrl_q <= {(N_PATTERNS+1){1'b0}};
            for (int p = 0; p < N_PATTERNS; p++) begin
                for (int w = 0; w < PW; w++) begin
                    pat_q[p][w] <= {AMM_DWIDTH{1'b0}};
                end
            end
            for (int c = 0; c <= N_PATTERNS; c++) begin
                cnt_q[c] <= {AMM_DWIDTH{1'b0}};
            end
            for (int k = 0; k < HB; k++) begin
                hist_q[k] <= 8'd0;
            end
            rdata_q    <= {AMM_DWIDTH{1'b0}};
            hist_cnt_q <= {HCW{1'b0}};
            hit_q      <= {N_PATTERNS{1'b0}};
            in_pkt_q   <= 1'b0;
            pkt_en_q   <= 1'b0;
            valid_q    <= 1'b0;
            data_q     <= {AST_DWIDTH{1'b0}};
            sop_q      <= 1'b0;
            eop_q      <= 1'b0;
            empty_q    <= {EW{1'b0}};
            chan_q     <= {CHANNEL_WIDTH{1'b0}};
        end else begin
            ctrl_q     <= ctrl_d;
            pat_q      <= pat_d;
            cnt_q      <= cnt_d;
            hist_q     <= hist_d;
            rdata_q    <= rdata_d;
            hist_cnt_q <= hist_cnt_d;
            hit_q      <= hit_d;
            in_pkt_q   <= in_pkt_d;
            pkt_en_q   <= pkt_en_d;
            valid_q    <= valid_d;
            data_q     <= data_d;
            sop_q      <= sop_d;
            eop_q      <= eop_d;
            empty_q    <= empty_d;
            chan_q     <= chan_d;
        end
    end

    assign ast_sink_if.ready          = sink_ready_s;
    assign ast_src_if.valid           = valid_q;
    assign ast_src_if.data            = data_q;
    assign ast_src_if.startofpacket   = sop_q;
    assign ast_src_if.endofpacket     = eop_q;
    assign ast_src_if.empty           = empty_q;
    assign ast_src_if.channel         = chan_q;
    assign amm_slave_if.readdata      = rdata_q;

endmodule
